// File: rtl/multicycle_control_fsm_if.sv
// Control bus between the multicycle datapath and its control FSM.
// The datapath side is master (supplies Opcode), the FSM is slave.
interface multicycle_control_fsm_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       Opcode;
  logic [2:0]       ALUOp;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       PCSource;
  logic             IRWrite;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             MemWrite;
  logic             RegWrite;
  logic             MemToReg;
  logic [3:0]       state_out;
  logic             halted;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output Opcode,
    input  ALUOp, ALUSrcA, ALUSrcB, PCSource,
    input  IRWrite, PCWrite, PCWriteCond,
    input  MemWrite, RegWrite, MemToReg,
    input  state_out, halted, instr_count
  );

  modport slave (
    input  Opcode,
    output ALUOp, ALUSrcA, ALUSrcB, PCSource,
    output IRWrite, PCWrite, PCWriteCond,
    output MemWrite, RegWrite, MemToReg,
    output state_out, halted, instr_count
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for the multicycle CPU: one state per clock,
// retired-instruction counter, halt on HALT or illegal opcode.
module multicycle_control_fsm #(
  parameter int CNT_W        = 32,
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic clk,
  input  logic reset,
  multicycle_control_fsm_if.slave bus
);

  typedef enum logic [3:0] {
    S_START  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXR    = 4'd7,
    S_RWB    = 4'd8,
    S_EXI    = 4'd9,
    S_IWB    = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_HALT   = 4'd13
  } state_t;

  typedef enum logic [2:0] {
    K_R, K_I, K_LW, K_SW,
    K_BNE, K_J, K_HALT, K_ILL
  } kind_t;

  state_t           state_q;
  state_t           state_d;
  kind_t            kind;
  logic [CNT_W-1:0] cnt_q;
  logic             retire;

  // Exact-match case: X/Z opcodes fall through to illegal.
  always_comb begin
    kind = K_ILL;
    case (bus.Opcode)
      6'b000000, 6'b000001, 6'b000010,
      6'b000011, 6'b000100, 6'b000101: kind = K_R;
      6'b001000, 6'b001001, 6'b001010,
      6'b001011, 6'b001100, 6'b001101: kind = K_I;
      6'b100011: kind = K_LW;
      6'b101011: kind = K_SW;
      6'b010001: kind = K_BNE;
      6'b010000: kind = K_J;
      6'b111111: kind = K_HALT;
      default:   kind = K_ILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_START;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_START:  state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (kind)
          K_LW, K_SW: state_d = S_MEMADR;
          K_R:        state_d = S_EXR;
          K_I:        state_d = S_EXI;
          K_BNE:      state_d = S_BRANCH;
          K_J:        state_d = S_JUMP;
          K_HALT:     state_d = S_HALT;
          default:    state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (kind == K_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXR:    state_d = S_RWB;
      S_EXI:    state_d = S_IWB;
      S_MEMWB, S_MEMWR, S_RWB,
      S_IWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_START;
    endcase
  end

  always_comb begin
    bus.ALUOp       = 3'b000;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.PCSource    = 2'b00;
    bus.IRWrite     = 1'b0;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.MemToReg    = 1'b0;
    bus.halted      = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        bus.IRWrite = 1'b1;
        bus.PCWrite = 1'b1;
        bus.ALUSrcB = 2'b01;
      end
      S_MEMADR, S_MEMRD: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      S_MEMWB: begin
        bus.MemToReg = 1'b1;
        bus.RegWrite = 1'b1;
      end
      S_MEMWR: begin
        bus.ALUSrcA  = 1'b1;
        bus.MemWrite = 1'b1;
      end
      S_EXR, S_RWB: begin
        bus.ALUSrcA  = 1'b1;
        bus.ALUOp    = bus.Opcode[2:0];
        bus.RegWrite = (state_q == S_RWB);
      end
      S_EXI, S_IWB: begin
        bus.ALUSrcA  = 1'b1;
        bus.ALUSrcB  = 2'b10;
        bus.ALUOp    = bus.Opcode[2:0];
        bus.RegWrite = (state_q == S_IWB);
      end
      S_BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = 3'b001;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
      end
      S_JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
      end
      S_HALT:  bus.halted = 1'b1;
      default: ;
    endcase
  end

  // Every final state of an instruction retires it on the way to FETCH.
  assign retire = (state_q == S_MEMWB)  || (state_q == S_MEMWR) ||
                  (state_q == S_RWB)    || (state_q == S_IWB)   ||
                  (state_q == S_BRANCH) || (state_q == S_JUMP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (retire) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.state_out   = state_q;
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm against an
// instruction-level reference model (state paths per opcode).
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] aluop;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic       irw;
    logic       pcw;
    logic       pcwc;
    logic       memw;
    logic       regw;
    logic       m2r;
    logic       halted;
  } obs_t;

  typedef int   path_t[7];
  typedef obs_t trace_t[7];

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op0 = 6'b010000;
  logic [5:0] op1 = 6'b010000;
  logic [5:0] op2 = 6'b010000;
  int         nchk = 0;
  int         nfail = 0;
  logic [31:0] mcnt[3];

  always #5 clk = ~clk;

  multicycle_control_fsm_if #(.CNT_W(32)) b0();
  multicycle_control_fsm_if #(.CNT_W(32)) b1();
  multicycle_control_fsm_if #(.CNT_W(4))  b2();

  assign b0.Opcode = op0;
  assign b1.Opcode = op1;
  assign b2.Opcode = op2;

  multicycle_control_fsm #(.CNT_W(32), .ILLEGAL_HALT(1'b1)) dut0 (
    .clk(clk), .reset(reset), .bus(b0));
  multicycle_control_fsm #(.CNT_W(32), .ILLEGAL_HALT(1'b0)) dut1 (
    .clk(clk), .reset(reset), .bus(b1));
  multicycle_control_fsm #(.CNT_W(4), .ILLEGAL_HALT(1'b1)) dut2 (
    .clk(clk), .reset(reset), .bus(b2));

  obs_t o0, o1, o2;
  assign o0 = {b0.state_out, b0.ALUOp, b0.ALUSrcA, b0.ALUSrcB,
               b0.PCSource, b0.IRWrite, b0.PCWrite, b0.PCWriteCond,
               b0.MemWrite, b0.RegWrite, b0.MemToReg, b0.halted};
  assign o1 = {b1.state_out, b1.ALUOp, b1.ALUSrcA, b1.ALUSrcB,
               b1.PCSource, b1.IRWrite, b1.PCWrite, b1.PCWriteCond,
               b1.MemWrite, b1.RegWrite, b1.MemToReg, b1.halted};
  assign o2 = {b2.state_out, b2.ALUOp, b2.ALUSrcA, b2.ALUSrcB,
               b2.PCSource, b2.IRWrite, b2.PCWrite, b2.PCWriteCond,
               b2.MemWrite, b2.RegWrite, b2.MemToReg, b2.halted};

  function automatic obs_t get_obs(input int k);
    case (k)
      0:       return o0;
      1:       return o1;
      default: return o2;
    endcase
  endfunction

  function automatic logic [31:0] get_cnt(input int k);
    case (k)
      0:       return b0.instr_count;
      1:       return b1.instr_count;
      default: return {28'd0, b2.instr_count};
    endcase
  endfunction

  task automatic set_op(input int k, input logic [5:0] v);
    case (k)
      0:       op0 = v;
      1:       op1 = v;
      default: op2 = v;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected strobes of each state, read straight off the state table.
  function automatic obs_t model_obs(input int s, input logic [5:0] op);
    obs_t o = '0;
    o.st = s[3:0];
    case (s)
      1:  begin o.irw = 1; o.pcw = 1; o.srcb = 2'b01; end
      3, 4: begin o.srca = 1; o.srcb = 2'b10; end
      5:  begin o.m2r = 1; o.regw = 1; end
      6:  begin o.srca = 1; o.memw = 1; end
      7, 8: begin o.srca = 1; o.aluop = op[2:0]; o.regw = (s == 8); end
      9, 10: begin
        o.srca = 1; o.srcb = 2'b10; o.aluop = op[2:0]; o.regw = (s == 10);
      end
      11: begin o.srca = 1; o.aluop = 3'b001; o.pcwc = 1; o.pcsrc = 2'b01; end
      12: begin o.pcw = 1; o.pcsrc = 2'b10; end
      13: o.halted = 1;
      default: ;
    endcase
    return o;
  endfunction

  // States visited from FETCH, plus the state reached afterwards.
  function automatic void model(input logic [5:0] op, input bit ih,
      output int n, output path_t p, output bit ret);
    int v = int'(op);
    p = '{default: 0};
    ret = 1;
    if (v <= 5)                 begin p[0:4] = '{1, 2, 7, 8, 1};  n = 5; end
    else if (v >= 8 && v <= 13) begin p[0:4] = '{1, 2, 9, 10, 1}; n = 5; end
    else if (v == 35) begin p[0:5] = '{1, 2, 3, 4, 5, 1}; n = 6; end
    else if (v == 43) begin p[0:4] = '{1, 2, 3, 6, 1};    n = 5; end
    else if (v == 17) begin p[0:3] = '{1, 2, 11, 1};      n = 4; end
    else if (v == 16) begin p[0:3] = '{1, 2, 12, 1};      n = 4; end
    else if (v == 63 || ih) begin
      p[0:3] = '{1, 2, 13, 13}; n = 4; ret = 0;
    end else begin
      p[0:2] = '{1, 2, 1}; n = 3; ret = 0;
    end
  endfunction

  // Runs one instruction from FETCH on DUT k, returning the trace.
  task automatic exec(input int k, input logic [5:0] op, output int n,
      output trace_t seen, output trace_t want);
    path_t p;
    bit    ret;
    model(op, (k != 1), n, p, ret);
    set_op(k, op);
    for (int i = 0; i < n; i++) begin
      seen[i] = get_obs(k);
      want[i] = model_obs(p[i], op);
      if (i < n - 1) step();
    end
    if (ret) mcnt[k] = (mcnt[k] + 1) & ((k == 2) ? 32'hF : 32'hFFFF_FFFF);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    mcnt = '{default: 0};
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      nchk++;
      if ({o0, o1, o2} !== '0) begin
        nfail++;
        $display("FAIL reset_strobes c%0d: got %h %h %h want 0", c, o0, o1, o2);
      end
      nchk++;
      if (get_cnt(0) !== 0 || get_cnt(2) !== 0) begin
        nfail++;
        $display("FAIL reset_count: got %0d/%0d want 0", get_cnt(0), get_cnt(2));
      end
    end
    reset = 1'b1;
    #2;
    nchk++;
    if (o0 !== '0) begin
      nfail++;
      $display("FAIL start_hold: got %h want 0", o0);
    end
    step();
    nchk++;
    if (o0 !== model_obs(1, op0)) begin
      nfail++;
      $display("FAIL start_to_fetch: got %h want %h", o0, model_obs(1, op0));
    end
    mcnt = '{default: 0};
  endtask

  // Runs an opcode table on DUT k and checks every state and the count.
  task automatic run_table(input string nm, input int k,
      input logic [5:0] ops[$]);
    trace_t seen, want;
    int     n;
    foreach (ops[j]) begin
      exec(k, ops[j], n, seen, want);
      for (int i = 0; i < n; i++) begin
        nchk++;
        if (seen[i] !== want[i]) begin
          nfail++;
          $display("FAIL %s op%b step%0d: got %h want %h",
                   nm, ops[j], i, seen[i], want[i]);
        end
      end
      nchk++;
      if (get_cnt(k) !== mcnt[k]) begin
        nfail++;
        $display("FAIL %s_count op%b: got %0d want %0d",
                 nm, ops[j], get_cnt(k), mcnt[k]);
      end
    end
  endtask

  task automatic test_lw();
    do_reset();
    run_table("lw", 0, '{6'b100011});
  endtask

  task automatic test_sw_r();
    do_reset();
    run_table("sw_sub", 0, '{6'b101011, 6'b000001});
  endtask

  task automatic test_branch_jump();
    do_reset();
    run_table("bne_j", 0, '{6'b010001, 6'b010000, 6'b001101});
  endtask

  task automatic test_illegal_halt();
    obs_t w;
    do_reset();
    run_table("illegal", 0, '{6'b000101, 6'b110000});
    w = model_obs(13, op0);
    for (int c = 0; c < 20; c++) begin
      step();
      nchk++;
      if (o0 !== w || get_cnt(0) !== mcnt[0]) begin
        nfail++;
        $display("FAIL halt_hold c%0d: got %h/%0d want %h/%0d",
                 c, o0, get_cnt(0), w, mcnt[0]);
      end
    end
    do_reset();
    run_table("halt_op", 0, '{6'b100011, 6'b111111});
  endtask

  task automatic test_illegal_nop();
    do_reset();
    run_table("nop", 1, '{6'b100011, 6'b110000, 6'b000111,
                          6'b001000, 6'b111111});
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_table("pre_mid", 0, '{6'b011001 ^ 6'b111010});
    op0 = 6'b100011;
    repeat (3) step();
    nchk++;
    if (o0 !== model_obs(4, op0)) begin
      nfail++;
      $display("FAIL reach_memrd: got %h want %h", o0, model_obs(4, op0));
    end
    #2 reset = 1'b0;
    #1;
    nchk++;
    if (o0 !== '0 || get_cnt(0) !== 0) begin
      nfail++;
      $display("FAIL async_reset: got %h/%0d want 0/0", o0, get_cnt(0));
    end
    do_reset();
    run_table("post_mid", 0, '{6'b101011});
  endtask

  task automatic test_wrap();
    logic [5:0] ops[$];
    do_reset();
    for (int i = 0; i < 15; i++) ops.push_back(6'b010001);
    run_table("wrap15", 2, ops);
    nchk++;
    if (get_cnt(2) !== 32'd15) begin
      nfail++;
      $display("FAIL wrap_at15: got %0d want 15", get_cnt(2));
    end
    run_table("wrap16", 2, '{6'b010000});
    nchk++;
    if (get_cnt(2) !== 32'd0) begin
      nfail++;
      $display("FAIL wrap_to0: got %0d want 0", get_cnt(2));
    end
  endtask

  task automatic test_random();
    logic [5:0] ops[$];
    logic [5:0] v;
    trace_t     seen, want;
    int         n;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0: v = 6'($urandom_range(0, 5));
        1: v = 6'(8 + $urandom_range(0, 5));
        2: v = 6'b100011;
        3: v = 6'b101011;
        4: v = 6'b010001;
        default: v = 6'b010000;
      endcase
      ops.push_back(v);
    end
    run_table("random", 0, ops);
    do_reset();
    for (int i = 0; i < 40; i++) begin
      exec(0, 6'($urandom_range(0, 62)), n, seen, want);
      for (int s = 0; s < n; s++) begin
        nchk++;
        if ((seen[s].pcw && seen[s].pcwc) || (seen[s].memw && seen[s].regw) ||
            seen[s].srcb === 2'b11) begin
          nfail++;
          $display("FAIL strobe_conflict: got %h want no overlap", seen[s]);
        end
      end
      if (o0.halted) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_r();
    test_branch_jump();
    test_illegal_halt();
    test_illegal_nop();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
